mult_seq: RTL and testbench

Iterative shift-add multiplier sequencer that replaces the single-cycle combinational multiplier path in the processor datapath. It accepts MULT/MULTU operands from the ALU operand buses and runs one partial-product step per cycle. While it works it stalls the PC, then presents a full 2×WIDTH product for write-back in the cycle the stall releases.

---
 rtl/mult_seq_pkg.sv | 22 ++
 rtl/mult_seq_dp.sv | 69 ++++++
 rtl/mult_seq.sv | 92 +++++++++
 tb/tb_mult_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types, sizing constants and helpers for the sequential multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  // Widest product the negation helper handles; callers zero-extend into it
  // and truncate the result, which is exact modulo 2^(2*WIDTH).
  localparam int unsigned NEG_W = 128;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Datapath of the shift-add multiplier: operand magnitudes, accumulator,
// one add-and-shift step per strobe, and the signed-corrected product.
// Vectors are numbered descending, so the sign bit is [WIDTH-1] and the
// multiplier bit consumed each step is [0].
module mult_seq_dp
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] mcand_q, mplr_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_q;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH:0]   upper_sum;
  logic [PW:0]      acc_wide;

  // Operand magnitudes, the next accumulator value and the final product.
  always_comb begin
    mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    upper_sum = {1'b0, acc_q[PW-1:WIDTH]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_wide  = {upper_sum, acc_q[WIDTH-1:0]};
    acc_d     = PW'(acc_wide >> 1);
    prod_d    = PW'(cond_neg(NEG_W'(acc_d), neg_q));
  end

  // Operand capture, iteration step and product load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      if (load) begin
        mcand_q <= mag_a;
        mplr_q  <= mag_b;
        neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_q   <= '0;
      end else if (step) begin
        acc_q  <= acc_d;
        mplr_q <= mplr_q >> 1;
      end
      if (finish) begin
        prod_q <= prod_d;
      end
    end
  end

  assign product_hi = prod_q[PW-1:WIDTH];
  assign product_lo = prod_q[WIDTH-1:0];

endmodule

// File: rtl/mult_seq.sv
// Iterative multiplier sequencer: accepts a multiply, stalls the PC for the
// issue cycle plus WIDTH iteration cycles, then flags the product for one cycle.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int unsigned      CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            load, step, finish;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Iteration counter, cleared on accept and advanced once per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign stall = reset & (((state_q == IDLE) & start) | (state_q == RUN));
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

  mult_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .product_hi(product_hi),
    .product_lo(product_lo)
  );

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: the driver pushes reference products, a
// negedge monitor pops and compares them whenever done is presented.
module tb_mult_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] a, b;
  logic         stall, busy, done;
  logic [W-1:0] product_hi, product_lo;

  int           checks = 0;
  int           errors = 0;
  logic [63:0]  exp_q[$];

  mult_seq #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .product_hi(product_hi),
    .product_lo(product_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = x;
    uy = y;
    return ux * uy;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one multiply; scramble perturbs inputs during RUN/DONE, chain
  // leaves start high so the next call issues right after DONE.
  task automatic run_mult(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input bit scramble, input bit chain);
    @(posedge clk); #1;
    a = x; b = y; signed_op = s; start = 1'b1;
    exp_q.push_back(ref_mul(x, y, s));
    @(posedge clk);  // accepting edge
    for (int i = 1; i <= int'(W); i++) begin
      #1;
      if (scramble) begin
        a = $urandom; b = $urandom; signed_op = 1'($urandom); start = 1'($urandom);
      end
      @(posedge clk);
    end
    #1;
    check("done_latency", {63'd0, done}, 64'd1);
    start = 1'b1;
    if (scramble) begin
      a = $urandom; b = $urandom; signed_op = 1'($urandom);
    end
    if (!chain) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // Monitor: stall length, single-cycle done, product compare and hold.
  int          stall_cnt;
  logic [63:0] held;
  logic        done_prev;
  always @(negedge clk) begin
    if (!reset) begin
      stall_cnt = 0;
      held      = '0;
      done_prev = 1'b0;
    end else begin
      if (stall) stall_cnt++;
      if (done) begin
        check("done_single_cycle", {63'd0, done_prev}, 64'd0);
        check("stall_cycles", 64'(stall_cnt), 64'(W + 1));
        check("busy_in_done", {63'd0, busy}, 64'd0);
        stall_cnt = 0;
        check("done_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          check("product", {product_hi, product_lo}, exp_q.pop_front());
        end
        held = {product_hi, product_lo};
      end else begin
        check("product_hold", {product_hi, product_lo}, held);
      end
      done_prev = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit chain;
    reset = 1'b0; start = 1'b1; signed_op = 1'b0; a = $urandom; b = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", {product_hi, product_lo}, 64'd0);
    #2;
    start = 1'b0;
    reset = 1'b1;

    run_mult(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    check("u_3x5", {product_hi, product_lo}, 64'h0000_0000_0000_000F);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("u_max_sq", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
    run_mult(32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
    check("s_m7x3", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    check("s_min_sq", {product_hi, product_lo}, 64'h4000_0000_0000_0000);

    run_mult(32'h1234_5678, 32'hFEDC_BA98, 1'b1, 1'b1, 1'b1);
    run_mult(32'hDEAD_BEEF, 32'h0000_0013, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      chain = (n != 19) && 1'($urandom);
      run_mult(pick(), pick(), 1'($urandom), 1'($urandom), chain);
    end

    // Asynchronous reset partway through an operation.
    @(posedge clk); #1;
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_stall", {63'd0, stall}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    @(posedge clk); #3;
    start = 1'b0;
    reset = 1'b1;

    run_mult(32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
    check("u_6x7", {product_hi, product_lo}, 64'h0000_0000_0000_002A);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
